// File: rtl/lbp_histogram_if.sv
// Bundles the LBP sample stream, the frame-end level and the histogram readout
// stream of lbp_histogram. The design side uses the slave modport.
interface lbp_histogram_if #(
  parameter int CNT_W = 14
);
  // Readout handshake: a bin transfers on a cycle where hist_valid and
  // hist_ready are both high; while hist_valid=1 and hist_ready=0,
  // hist_bin/hist_count hold. hist_valid never drops without a transfer.
  logic             lbp_valid;
  logic [13:0]      lbp_addr;
  logic [7:0]       lbp_data;
  logic             finish;
  logic             hist_valid;
  logic             hist_ready;
  logic [7:0]       hist_bin;
  logic [CNT_W-1:0] hist_count;
  logic             hist_done;
  logic             border_err;
  logic             overrun;
  logic [1:0]       dbg_state;

  modport master (
    output lbp_valid, lbp_addr, lbp_data, finish, hist_ready,
    input  hist_valid, hist_bin, hist_count, hist_done, border_err, overrun, dbg_state
  );

  modport slave (
    input  lbp_valid, lbp_addr, lbp_data, finish, hist_ready,
    output hist_valid, hist_bin, hist_count, hist_done, border_err, overrun, dbg_state
  );
endinterface

// File: rtl/lbp_histogram.sv
// 256-bin histogram of LBP codes for one frame; on the finish rising edge the
// bins are streamed out (and cleared) one per handshake.
module lbp_histogram #(
  parameter int CNT_W = 14,
  parameter int IMG_W = 128,
  parameter int IMG_H = 128
) (
  input logic             clk,
  input logic             reset,
  lbp_histogram_if.slave  bus
);

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    DUMP  = 2'd2
  } state_t;

  localparam int               ROW_SH   = $clog2(IMG_W);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [14:0]      NPIX     = 15'(IMG_W * IMG_H);
  localparam logic [13:0]      COL_LAST = 14'(IMG_W - 1);
  localparam logic [13:0]      ROW_LAST = 14'(IMG_H - 1);

  state_t           state_q, state_d;
  logic             drain_q, drain_d;
  logic             finish_q, finish_d;
  logic             s1_valid_q, s1_valid_d;
  logic [7:0]       s1_bin_q, s1_bin_d;
  logic [CNT_W-1:0] s1_cnt_q, s1_cnt_d;
  logic [CNT_W-1:0] bins_q [256];
  logic [CNT_W-1:0] bins_d [256];
  logic             hist_valid_q, hist_valid_d;
  logic [7:0]       hist_bin_q, hist_bin_d;
  logic [CNT_W-1:0] hist_count_q, hist_count_d;
  logic             hist_done_q, hist_done_d;
  logic             border_err_q, border_err_d;
  logic             overrun_q, overrun_d;

  logic [13:0]      row, col;
  logic             is_border;
  logic             finish_rise;
  logic [CNT_W-1:0] s2_val;
  logic [7:0]       next_ptr;

  assign row         = bus.lbp_addr >> ROW_SH;
  assign col         = bus.lbp_addr & COL_LAST;
  assign is_border   = (row == '0) || (row == ROW_LAST) || (col == '0) || (col == COL_LAST) ||
                       ({1'b0, bus.lbp_addr} >= NPIX);
  assign finish_rise = bus.finish & ~finish_q;
  assign s2_val      = (s1_cnt_q == CNT_MAX) ? CNT_MAX : s1_cnt_q + CNT_W'(1);
  assign next_ptr    = hist_bin_q + 8'd1;

  always_comb begin
    state_d      = state_q;
    drain_d      = drain_q;
    finish_d     = bus.finish;
    s1_valid_d   = 1'b0;
    s1_bin_d     = bus.lbp_data;
    // A sample hitting the bin being written this cycle takes the new value,
    // since the array read would still return the stale count.
    s1_cnt_d     = (s1_valid_q && (s1_bin_q == bus.lbp_data)) ? s2_val : bins_q[bus.lbp_data];
    bins_d       = bins_q;
    hist_valid_d = hist_valid_q;
    hist_bin_d   = hist_bin_q;
    hist_count_d = hist_count_q;
    hist_done_d  = 1'b0;
    border_err_d = border_err_q;
    overrun_d    = overrun_q;

    if (s1_valid_q) bins_d[s1_bin_q] = s2_val;

    unique case (state_q)
      ACCUM: begin
        if (bus.lbp_valid) begin
          if (is_border) border_err_d = 1'b1;
          else           s1_valid_d   = 1'b1;
        end
        if (finish_rise) begin
          state_d = DRAIN;
          drain_d = 1'b0;
        end
      end
      DRAIN: begin
        if (bus.lbp_valid) overrun_d = 1'b1;
        if (drain_q) begin
          state_d      = DUMP;
          hist_valid_d = 1'b1;
          hist_bin_d   = 8'd0;
          hist_count_d = bins_q[8'd0];
        end else begin
          drain_d = 1'b1;
        end
      end
      DUMP: begin
        if (bus.lbp_valid) overrun_d = 1'b1;
        if (hist_valid_q && bus.hist_ready) begin
          bins_d[hist_bin_q] = '0;
          if (hist_bin_q == 8'hFF) begin
            hist_valid_d = 1'b0;
            hist_done_d  = 1'b1;
            state_d      = ACCUM;
          end else begin
            // Prefetch the next bin so one bin transfers per cycle.
            hist_bin_d   = next_ptr;
            hist_count_d = bins_q[next_ptr];
          end
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ACCUM;
      drain_q      <= 1'b0;
      finish_q     <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_bin_q     <= '0;
      s1_cnt_q     <= '0;
      bins_q       <= '{default: '0};
      hist_valid_q <= 1'b0;
      hist_bin_q   <= '0;
      hist_count_q <= '0;
      hist_done_q  <= 1'b0;
      border_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      drain_q      <= drain_d;
      finish_q     <= finish_d;
      s1_valid_q   <= s1_valid_d;
      s1_bin_q     <= s1_bin_d;
      s1_cnt_q     <= s1_cnt_d;
      bins_q       <= bins_d;
      hist_valid_q <= hist_valid_d;
      hist_bin_q   <= hist_bin_d;
      hist_count_q <= hist_count_d;
      hist_done_q  <= hist_done_d;
      border_err_q <= border_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.hist_valid = hist_valid_q;
  assign bus.hist_bin   = hist_bin_q;
  assign bus.hist_count = hist_count_q;
  assign bus.hist_done  = hist_done_q;
  assign bus.border_err = border_err_q;
  assign bus.overrun    = overrun_q;
  assign bus.dbg_state  = state_q;

endmodule
